uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmit path (rs232_send-style byte sender) among NUM_REQ byte-stream requesters.
Grants whole packets (delimited by a last flag) in round-robin order, so bytes from different requesters never interleave on the serial line.
Sits between the per-function producers (loopback, status reporter, debug dump) and the tx circular buffer / sender.
Output is a registered valid/ready byte stream.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, mid-packet stall limit in clk cycles (used only with PKT_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  input  NUM_REQ  byte is final byte of packet
req_ready  output  NUM_REQ  byte accepted when req_valid[i] & req_ready[i] at clk edge
tx_data  output  8  byte to sender / tx buffer
tx_valid  output  1  tx_data valid
tx_ready  input  1  downstream accepts when tx_valid & tx_ready at clk edge
grant  output  NUM_REQ  one-hot current owner; all-zero when idle
busy  output  1  high whenever state is SEND or tx_valid is high
timeout  output  1  one-cycle pulse on forced release (PKT_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (rst=1 at edge): state IDLE, grant=0, tx_valid=0, tx_data=8'h00, req_ready=0, timeout=0, rr_ptr=NUM_REQ-1 (requester 0 wins first). Reset mid-packet discards the held output byte and the partial packet; nothing resumes.
- States: IDLE, SEND.
- IDLE: if any req_valid, pick the first set index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register grant one-hot, go to SEND. req_ready=0 in IDLE. No valid: stay IDLE.
- SEND: req_ready[g] = (!tx_valid | tx_ready) for granted g; all other req_ready=0 (combinational from state, grant, tx_valid, tx_ready).
- Output register: on accept, tx_data<=req_data[g], tx_valid<=1 at that edge (1-cycle latency). If tx_ready drains with no new accept, tx_valid<=0. Accept and drain on the same edge: tx_valid stays 1 with the new byte; full throughput of 1 byte/clk.
- Accept with req_last[g]=1: next state IDLE, rr_ptr<=g, grant<=0. The held last byte still drains normally from IDLE (busy stays high until it does).
- Minimum one IDLE cycle between packets; arbitration never happens in the same cycle as a last-byte accept.
- Requester dropping req_valid mid-packet: grant held indefinitely (without feature).
- req_valid on non-granted requesters has no effect in SEND; their data must be held stable until accepted.
- Single-byte packet (last on first byte) is legal: IDLE->SEND->IDLE.
- Byte values pass through unmodified; no width conversion.

Optional Feature:
PKT_TIMEOUT_EN defined: 16-bit stall counter clears on every accept and on entering SEND; increments in SEND while req_valid[g]=0. When it reaches TIMEOUT_CYCLES: go IDLE, rr_ptr<=g, grant<=0, timeout pulses high 1 cycle. The already-held tx byte still drains.
Not defined: no counter; timeout tied 0; grant held until last.

Test Plan:
- Reset, then req0 sends 3 bytes 8'h41,8'h42,8'h43 (last on 8'h43), tx_ready=1 -> tx_data shows 41,42,43 on consecutive cycles, 1 cycle after each accept; grant=4'b0001 then 0; busy falls after 43 drains.
- req0 and req2 both valid with 2-byte packets from reset -> req0 packet fully first, one IDLE cycle, then req2; no interleave. Repeat with both still valid -> next grant goes to req2's successor in order (req0 only after req2).
- tx_ready=0 for 5 cycles mid-packet -> tx_valid stays 1, tx_data stable, req_ready[g]=0; resumes without byte loss or duplication when tx_ready=1.
- Assert rst while tx_valid=1 holding byte 8'h7E in SEND -> next cycle tx_valid=0, grant=0, tx_data=0; req0 wins next arbitration.
- With PKT_TIMEOUT_EN, TIMEOUT_CYCLES=8: req1 sends 1 non-last byte then drops valid -> after 8 idle cycles timeout pulses once, grant=0; pending req3 granted after one IDLE cycle.
- All 4 requesters sending single-byte packets continuously -> grants rotate 0,1,2,3,0 with one byte every 2 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART byte sender from NUM_REQ streams.
// Define PKT_TIMEOUT_EN to force-release a grant whose owner stalls mid-packet for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_found;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               can_load;
  logic               accept;
  logic               end_pkt;
  logic               stall_release;
  logic               send_nxt;
  logic               tx_valid_nxt;

  // Index of the current owner (grant is one-hot or zero)
  always_comb begin
    gidx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) gidx = IDX_W'(i);
    end
  end

  // Round-robin search starting just after the last owner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_REQ));
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_valid    = req_valid[gidx];
    sel_last     = req_last[gidx];
    sel_data     = req_data[{gidx, 3'b000} +: 8];
    can_load     = !tx_valid || tx_ready;
    accept       = (state == SEND) && sel_valid && can_load;
    end_pkt      = accept && sel_last;
    tx_valid_nxt = accept || (tx_valid && !tx_ready);
    req_ready    = (state == SEND && can_load) ? grant : '0;
  end

  always_comb begin
    send_nxt = 1'b0;
    case (state)
      IDLE:    send_nxt = pick_found;
      SEND:    send_nxt = !(end_pkt || stall_release);
      default: send_nxt = 1'b0;
    endcase
  end

`ifdef PKT_TIMEOUT_EN
  logic [15:0] stall_cnt;

  // Counts consecutive cycles the owner has nothing to offer; held at zero outside SEND
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE || accept) begin
      stall_cnt <= '0;
    end else if (!sel_valid) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_release = (state == SEND) && !sel_valid &&
                         (stall_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign stall_release      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= send_nxt ? SEND : IDLE;
      tx_valid <= tx_valid_nxt;
      busy     <= send_nxt || tx_valid_nxt;
      timeout  <= stall_release;
      if (accept) tx_data <= sel_data;
      if (state == IDLE && pick_found) begin
        grant <= NUM_REQ'(1) << pick_idx;
      end else if (state == SEND && !send_nxt) begin
        // Packet end or forced release: successor search starts after this owner
        grant  <= '0;
        rr_ptr <= gidx;
      end
    end
  end

endmodule
